vga_video_gen: RTL and testbench
================================

Name: vga_video_gen

Overview:
Parametrised successor to the fixed 640x480 sync/pattern path. It generates programmable horizontal and vertical timing and presents pixel coordinates to an external pixel source with known fixed latency. It delays sync and visible by that latency and outputs registered, blank-gated RGB aligned with hsync/vsync. It sits between the PLL/pixel clock and the board pin mapping, replacing the separate sync block and the pattern-to-pin glue.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
HSYNC_POL, 0, active level of hsync (0 = active-low)
VSYNC_POL, 0, active level of vsync
COLOR_BITS, 4, bits per colour channel
COORD_BITS, 10, width of column/row; must hold H_TOTAL-1 and V_TOTAL-1
PIPE_DELAY, 2, cycles from column/row to valid red_in/green_in/blue_in; 0 legal

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  clock enable; all state advances only when high
column  out  COORD_BITS  current horizontal counter
row  out  COORD_BITS  current vertical counter
coord_visible  out  1  column<H_VISIBLE and row<V_VISIBLE, same cycle as column/row
line_start  out  1  high while column==0
frame_start  out  1  high while column==0 and row==0
red_in/green_in/blue_in  in  COLOR_BITS each  pixel colour for the coordinate presented PIPE_DELAY enabled cycles earlier
red/green/blue  out  COLOR_BITS each  registered, blank-gated colour
hsync  out  1  delayed, registered hsync
vsync  out  1  delayed, registered vsync
visible  out  1  delayed, registered visible, aligned with RGB

Behaviour:
- Decided: one clock; reset is asynchronous and active-low.
- H_TOTAL = sum of the four H params (default 800); V_TOTAL likewise (default 525).
- Counters: h increments 0..H_TOTAL-1 then wraps to 0. v increments when h wraps and wraps 0..V_TOTAL-1. column and row are the counter registers themselves.
- Raw hsync is active for h in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751 by default). Raw vsync is active for v in [V_VISIBLE+V_FRONT, +V_SYNC-1] (490..491); it changes at h==0.
- Delay line: raw hsync, vsync and coord_visible pass through PIPE_DELAY enabled stages, then one output register. RGB inputs are sampled in the same output register.
- Output-to-coordinate latency is PIPE_DELAY+1 enabled cycles.
- Output register: red/green/blue = colour_in if the delayed visible is set, else 0. hsync/vsync take the delayed value at the polarity given by *_POL.
- enable low: counters, delay stages and output registers all hold; the outputs are stable.
- Reset (asserted any time, including mid-frame): h=v=0 immediately. All delay stages load invisible/sync-inactive. RGB=0, visible=0, hsync=!HSYNC_POL, vsync=!VSYNC_POL.
- On the first enabled cycle after release, column=0, row=0 and frame_start=1.
- Garbage colour on red_in/green_in/blue_in during blanking never reaches the outputs.
- No overflow: COORD_BITS too small for the totals is a configuration error. The implementation flags it with an elaboration-time check.

Decomposition:
- Shared header vga_timing.vh holds the default 640x480@60 constants (H_*/V_*) and H_TOTAL/V_TOTAL derivation macros, reused by pattern generators and benches.
- One natural sub-module: vga_delay_line.
  - Parameters WIDTH, DEPTH, RESET_VAL; enable input; DEPTH=0 is a wire.
  - Instantiated once for the {hsync, vsync, visible} bundle.

Test Plan:
1. Defaults, enable=1, release reset → hsync first goes low at cycle 659 and stays low 96 cycles; line period 800; column sequence 0..799 wraps.
2. Defaults → vsync low from cycle 392003 (490*800+3) for exactly 1600 cycles; frame period 420000; frame_start pulses once per frame.
3. red_in/green_in/blue_in held at 0xF → RGB=0xF exactly at output cycles 3..642 of lines 0..479, 0 elsewhere; visible matches.
4. Model source returning column[3:0] with 2-cycle latency → at each visible output, red equals the delayed column's low nibble (e.g. red=5 for pixel 5); repeat with PIPE_DELAY=0 and a combinational source.
5. enable toggled high 1-of-2 cycles → line period 1600 clocks, hsync width 192 clocks; all outputs constant on disabled cycles.
6. Assert reset_n=0 asynchronously at row 100 during a visible pixel → same-edge-independent RGB=0, hsync=vsync=1, column=row=0; after release, timing restarts from step 1 values; repeat with HSYNC_POL=1 → hsync idles 0.

Source files
------------

// File: rtl/vga_video_gen_pkg.sv
// Shared timing defaults (640x480@60), total-derivation helpers and the
// bundle type carried through the sync/visible delay line.
package vga_video_gen_pkg;

  // Default 640x480@60 horizontal timing, in pixels
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;

  // Default 640x480@60 vertical timing, in lines
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  // Raw (active-high) timing flags that travel together through the delay line
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic visible;
  } sync_bundle_t;

  // Full period of one axis: visible + front porch + sync + back porch
  function automatic int timing_total(input int vis, input int front,
                                      input int sync, input int back);
    return vis + front + sync + back;
  endfunction

  // True when a counter of 'bits' bits can hold every value 0..total-1
  function automatic bit fits_in_bits(input longint total, input int bits);
    return (total >= 1) && (total <= (longint'(1) << bits));
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register of DEPTH stages; DEPTH=0 degenerates to a wire.
// Every stage resets to RESET_VAL so nothing spurious leaves after reset.
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, reset_n, enable};
    assign dout      = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_reg [DEPTH];

    // Shift one stage per enabled cycle; hold everything while disabled
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) stage_reg[i] <= RESET_VAL;
      end else if (enable) begin
        stage_reg[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
      end
    end

    assign dout = stage_reg[DEPTH-1];
  end

endmodule

// File: rtl/vga_video_gen.sv
// Programmable VGA timing generator: exposes the current pixel coordinate to
// an external pixel source, delays sync/visible by that source's latency and
// registers blank-gated RGB aligned with hsync/vsync.
module vga_video_gen
  import vga_video_gen_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int COLOR_BITS = 4,
  parameter int COORD_BITS = 10,
  parameter int PIPE_DELAY = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  output logic [COORD_BITS-1:0] column,
  output logic [COORD_BITS-1:0] row,
  output logic                  coord_visible,
  output logic                  line_start,
  output logic                  frame_start,
  input  logic [COLOR_BITS-1:0] red_in,
  input  logic [COLOR_BITS-1:0] green_in,
  input  logic [COLOR_BITS-1:0] blue_in,
  output logic [COLOR_BITS-1:0] red,
  output logic [COLOR_BITS-1:0] green,
  output logic [COLOR_BITS-1:0] blue,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  visible
);

  localparam int H_TOTAL = timing_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = timing_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  // Configurations whose totals overflow the coordinate counters are rejected
  if (!fits_in_bits(H_TOTAL, COORD_BITS)) begin : g_h_overflow
    $error("vga_video_gen: COORD_BITS too small for H_TOTAL");
  end
  if (!fits_in_bits(V_TOTAL, COORD_BITS)) begin : g_v_overflow
    $error("vga_video_gen: COORD_BITS too small for V_TOTAL");
  end
  if (PIPE_DELAY < 0) begin : g_bad_delay
    $error("vga_video_gen: PIPE_DELAY must be non-negative");
  end

  localparam logic [COORD_BITS-1:0] H_LAST     = COORD_BITS'(H_TOTAL - 1);
  localparam logic [COORD_BITS-1:0] V_LAST     = COORD_BITS'(V_TOTAL - 1);
  localparam logic [COORD_BITS-1:0] H_VIS_LIM  = COORD_BITS'(H_VISIBLE);
  localparam logic [COORD_BITS-1:0] V_VIS_LIM  = COORD_BITS'(V_VISIBLE);
  localparam logic [COORD_BITS-1:0] HS_FIRST   = COORD_BITS'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_BITS-1:0] HS_LAST    = COORD_BITS'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_BITS-1:0] VS_FIRST   = COORD_BITS'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_BITS-1:0] VS_LAST    = COORD_BITS'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic                  HS_ACTIVE  = (HSYNC_POL != 0);
  localparam logic                  VS_ACTIVE  = (VSYNC_POL != 0);

  logic [COORD_BITS-1:0] h_reg;
  logic [COORD_BITS-1:0] v_reg;
  sync_bundle_t          raw_bundle;
  sync_bundle_t          dly_bundle;

  // Raster counters: h sweeps the line, v advances when h wraps
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_reg <= '0;
      v_reg <= '0;
    end else if (enable) begin
      if (h_reg == H_LAST) begin
        h_reg <= '0;
        v_reg <= (v_reg == V_LAST) ? '0 : v_reg + COORD_BITS'(1);
      end else begin
        h_reg <= h_reg + COORD_BITS'(1);
      end
    end
  end

  assign column        = h_reg;
  assign row           = v_reg;
  assign coord_visible = (h_reg < H_VIS_LIM) && (v_reg < V_VIS_LIM);
  assign line_start    = (h_reg == '0);
  assign frame_start   = (h_reg == '0) && (v_reg == '0);

  // Raw sync flags are kept active-high internally; polarity is applied at the pins
  assign raw_bundle.hsync   = (h_reg >= HS_FIRST) && (h_reg <= HS_LAST);
  assign raw_bundle.vsync   = (v_reg >= VS_FIRST) && (v_reg <= VS_LAST);
  assign raw_bundle.visible = coord_visible;

  vga_delay_line #(
    .WIDTH     ($bits(sync_bundle_t)),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL ('0)
  ) u_sync_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .din     (raw_bundle),
    .dout    (dly_bundle)
  );

  // Output register: colour is gated by the delayed visible so blanking garbage never escapes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      red     <= '0;
      green   <= '0;
      blue    <= '0;
      visible <= 1'b0;
      hsync   <= ~HS_ACTIVE;
      vsync   <= ~VS_ACTIVE;
    end else if (enable) begin
      red     <= dly_bundle.visible ? red_in   : '0;
      green   <= dly_bundle.visible ? green_in : '0;
      blue    <= dly_bundle.visible ? blue_in  : '0;
      visible <= dly_bundle.visible;
      hsync   <= dly_bundle.hsync ? HS_ACTIVE : ~HS_ACTIVE;
      vsync   <= dly_bundle.vsync ? VS_ACTIVE : ~VS_ACTIVE;
    end
  end

endmodule

// File: tb/tb_vga_video_gen.sv
// Bench for vga_video_gen: three instances (default timing with a 2-cycle
// source, PIPE_DELAY=0 with a combinational source, and a tiny raster with
// active-high syncs) checked against an index-based timing model.
module tb_vga_video_gen;

  logic clk;
  logic reset_n;
  logic enable;
  int   checks;
  int   errors;

  always #5 clk = ~clk;

  // ---------------- instance A: defaults, 2-cycle pixel source ----------------
  logic [9:0] column_a, row_a;
  logic       coord_visible_a, line_start_a, frame_start_a;
  logic [3:0] red_a, green_a, blue_a, green_in_a;
  logic       hsync_a, vsync_a, visible_a;
  logic [3:0] src1, src2;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src1 <= 4'h0;
      src2 <= 4'h0;
    end else if (enable) begin
      src1 <= column_a[3:0];
      src2 <= src1;
    end
  end
  assign green_in_a = src2;

  vga_video_gen dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .column(column_a), .row(row_a), .coord_visible(coord_visible_a),
    .line_start(line_start_a), .frame_start(frame_start_a),
    .red_in(4'hF), .green_in(green_in_a), .blue_in(4'h9),
    .red(red_a), .green(green_a), .blue(blue_a),
    .hsync(hsync_a), .vsync(vsync_a), .visible(visible_a)
  );

  // ---------------- instance B: PIPE_DELAY=0, combinational source ----------------
  logic [9:0] column_b, row_b;
  logic       coord_visible_b, line_start_b, frame_start_b;
  logic [3:0] red_b, green_b, blue_b;
  logic       hsync_b, vsync_b, visible_b;

  vga_video_gen #(.PIPE_DELAY(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .column(column_b), .row(row_b), .coord_visible(coord_visible_b),
    .line_start(line_start_b), .frame_start(frame_start_b),
    .red_in(4'hF), .green_in(column_b[3:0]), .blue_in(4'h9),
    .red(red_b), .green(green_b), .blue(blue_b),
    .hsync(hsync_b), .vsync(vsync_b), .visible(visible_b)
  );

  // ---------------- instance C: 16x10 raster, active-high syncs ----------------
  logic [3:0] column_c, row_c;
  logic       coord_visible_c, line_start_c, frame_start_c;
  logic [3:0] red_c, green_c, blue_c;
  logic       hsync_c, vsync_c, visible_c;

  vga_video_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(1), .VSYNC_POL(1), .COORD_BITS(4), .PIPE_DELAY(2)
  ) dut_c (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .column(column_c), .row(row_c), .coord_visible(coord_visible_c),
    .line_start(line_start_c), .frame_start(frame_start_c),
    .red_in(4'hF), .green_in(4'h6), .blue_in(4'h3),
    .red(red_c), .green(green_c), .blue(blue_c),
    .hsync(hsync_c), .vsync(vsync_c), .visible(visible_c)
  );

  wire [37:0] act_a = {column_a, row_a, coord_visible_a, line_start_a, frame_start_a,
                       visible_a, hsync_a, vsync_a, red_a, green_a, blue_a};
  wire [37:0] act_b = {column_b, row_b, coord_visible_b, line_start_b, frame_start_b,
                       visible_b, hsync_b, vsync_b, red_b, green_b, blue_b};
  wire [25:0] act_c = {column_c, row_c, coord_visible_c, line_start_c, frame_start_c,
                       visible_c, hsync_c, vsync_c, red_c, green_c, blue_c};

  // ---------------- reference timing model ----------------
  // k = number of enabled clock edges since reset release
  typedef struct {
    int col; int row; bit cvis; bit ls; bit fs; bit vis; bit hs; bit vs; int hx;
  } tm_t;

  function automatic tm_t model(input int k, input int d,
                                input int hv, input int hf, input int hsw, input int hb,
                                input int vv, input int vf, input int vsw, input int vb);
    tm_t e;
    int  ht, vt, c, vy;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    e.col  = k % ht;
    e.row  = (k / ht) % vt;
    e.cvis = (e.col < hv) && (e.row < vv);
    e.ls   = (e.col == 0);
    e.fs   = e.ls && (e.row == 0);
    e.vis  = 0; e.hs = 0; e.vs = 0; e.hx = 0;
    if (k >= d + 1) begin
      c     = k - d - 1;
      e.hx  = c % ht;
      vy    = (c / ht) % vt;
      e.vis = (e.hx < hv) && (vy < vv);
      e.hs  = (e.hx >= hv + hf) && (e.hx < hv + hf + hsw);
      e.vs  = (vy >= vv + vf) && (vy < vv + vf + vsw);
    end
    return e;
  endfunction

  function automatic logic [37:0] exp_def(input int k, input int d);
    tm_t        e;
    logic [3:0] g;
    e = model(k, d, 640, 16, 96, 48, 480, 10, 2, 33);
    g = e.vis ? 4'(e.hx) : 4'h0;
    return {10'(e.col), 10'(e.row), e.cvis, e.ls, e.fs, e.vis, ~e.hs, ~e.vs,
            e.vis ? 4'hF : 4'h0, g, e.vis ? 4'h9 : 4'h0};
  endfunction

  function automatic logic [25:0] exp_c(input int k);
    tm_t e;
    e = model(k, 2, 8, 2, 3, 3, 6, 1, 2, 1);
    return {4'(e.col), 4'(e.row), e.cvis, e.ls, e.fs, e.vis, e.hs, e.vs,
            e.vis ? 4'hF : 4'h0, e.vis ? 4'h6 : 4'h0, e.vis ? 4'h3 : 4'h0};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (act_a !== exp_def(0, 2)) begin
      errors++; $display("FAIL reset_a actual=%h expected=%h", act_a, exp_def(0, 2));
    end
    checks++;
    if (act_b !== exp_def(0, 0)) begin
      errors++; $display("FAIL reset_b actual=%h expected=%h", act_b, exp_def(0, 0));
    end
    checks++;
    if (act_c !== exp_c(0)) begin
      errors++; $display("FAIL reset_c actual=%h expected=%h", act_c, exp_c(0));
    end
    checks++;
    if ({hsync_c, vsync_c} !== 2'b00) begin
      errors++; $display("FAIL reset_pol1_idle actual=%b expected=00", {hsync_c, vsync_c});
    end
  endtask

  task automatic test_timing();
    int k, first_low_a, first_low_b, low_cnt_a, fs_cnt_c;
    bit bad_a, bad_b, bad_c;
    k = 0; first_low_a = -1; first_low_b = -1; low_cnt_a = 0; fs_cnt_c = 0;
    bad_a = 0; bad_b = 0; bad_c = 0;
    @(negedge clk);
    enable  = 1'b1;
    reset_n = 1'b1;
    #1;
    checks++;
    if ({column_a, row_a, frame_start_a} !== 21'h1) begin
      errors++; $display("FAIL first_cycle_coord actual=%h expected=000001", {column_a, row_a, frame_start_a});
    end
    for (int n = 0; n < 1700; n++) begin
      @(posedge clk);
      k++;
      #1;
      if (!bad_a) begin
        checks++;
        if (act_a !== exp_def(k, 2)) begin
          errors++; bad_a = 1;
          $display("FAIL timing_a k=%0d actual=%h expected=%h", k, act_a, exp_def(k, 2));
        end
      end
      if (!bad_b) begin
        checks++;
        if (act_b !== exp_def(k, 0)) begin
          errors++; bad_b = 1;
          $display("FAIL timing_b k=%0d actual=%h expected=%h", k, act_b, exp_def(k, 0));
        end
      end
      if (!bad_c) begin
        checks++;
        if (act_c !== exp_c(k)) begin
          errors++; bad_c = 1;
          $display("FAIL timing_c k=%0d actual=%h expected=%h", k, act_c, exp_c(k));
        end
      end
      if (hsync_a === 1'b0 && first_low_a < 0) first_low_a = k;
      if (hsync_b === 1'b0 && first_low_b < 0) first_low_b = k;
      if (hsync_a === 1'b0 && k < 800) low_cnt_a++;
      if (frame_start_c === 1'b1) fs_cnt_c++;
    end
    checks++;
    if (first_low_a != 659) begin
      errors++; $display("FAIL hsync_first_low_a actual=%0d expected=659", first_low_a);
    end
    checks++;
    if (low_cnt_a != 96) begin
      errors++; $display("FAIL hsync_width_a actual=%0d expected=96", low_cnt_a);
    end
    checks++;
    if (first_low_b != 657) begin
      errors++; $display("FAIL hsync_first_low_b actual=%0d expected=657", first_low_b);
    end
    checks++;
    if (fs_cnt_c != 10) begin
      errors++; $display("FAIL frame_start_count_c actual=%0d expected=10", fs_cnt_c);
    end
  endtask

  task automatic test_enable();
    int k, low_clk, rise0, rise1, nrise;
    bit bad_a, bad_c, prev_ls;
    k = 0; low_clk = 0; rise0 = -1; rise1 = -1; nrise = 0;
    bad_a = 0; bad_c = 0; prev_ls = 1;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int t = 0; t < 3210; t++) begin
      if (t > 0) @(negedge clk);
      enable = (t % 2 == 0);
      @(posedge clk);
      if (enable) k++;
      #1;
      if (!bad_a) begin
        checks++;
        if (act_a !== exp_def(k, 2)) begin
          errors++; bad_a = 1;
          $display("FAIL enable_a t=%0d k=%0d actual=%h expected=%h", t, k, act_a, exp_def(k, 2));
        end
      end
      if (!bad_c) begin
        checks++;
        if (act_c !== exp_c(k)) begin
          errors++; bad_c = 1;
          $display("FAIL enable_c t=%0d k=%0d actual=%h expected=%h", t, k, act_c, exp_c(k));
        end
      end
      if (hsync_a === 1'b0 && k < 800) low_clk++;
      if (line_start_a === 1'b1 && !prev_ls) begin
        if (nrise == 0) rise0 = t; else if (nrise == 1) rise1 = t;
        nrise++;
      end
      prev_ls = (line_start_a === 1'b1);
    end
    enable = 1'b1;
    checks++;
    if (low_clk != 192) begin
      errors++; $display("FAIL enable_hsync_clocks actual=%0d expected=192", low_clk);
    end
    checks++;
    if (rise1 - rise0 != 1600) begin
      errors++; $display("FAIL enable_line_period actual=%0d expected=1600", rise1 - rise0);
    end
  endtask

  task automatic test_reset_midframe();
    int k, first_low_a;
    bit bad_a, bad_b, bad_c;
    k = 0; first_low_a = -1; bad_a = 0; bad_b = 0; bad_c = 0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (1100) @(posedge clk);
    k = 1100;
    #1;
    checks++;
    if ({visible_a, red_a} !== 5'h1F) begin
      errors++; $display("FAIL pre_reset_visible actual=%h expected=1f", {visible_a, red_a});
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (act_a !== exp_def(0, 2)) begin
      errors++; $display("FAIL async_reset_a actual=%h expected=%h", act_a, exp_def(0, 2));
    end
    checks++;
    if (act_b !== exp_def(0, 0)) begin
      errors++; $display("FAIL async_reset_b actual=%h expected=%h", act_b, exp_def(0, 0));
    end
    checks++;
    if (act_c !== exp_c(0)) begin
      errors++; $display("FAIL async_reset_c actual=%h expected=%h", act_c, exp_c(0));
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (act_a !== exp_def(0, 2)) begin
      errors++; $display("FAIL reset_hold_a actual=%h expected=%h", act_a, exp_def(0, 2));
    end
    @(negedge clk);
    reset_n = 1'b1;
    k = 0;
    for (int n = 0; n < 800; n++) begin
      @(posedge clk);
      k++;
      #1;
      if (!bad_a) begin
        checks++;
        if (act_a !== exp_def(k, 2)) begin
          errors++; bad_a = 1;
          $display("FAIL restart_a k=%0d actual=%h expected=%h", k, act_a, exp_def(k, 2));
        end
      end
      if (!bad_b) begin
        checks++;
        if (act_b !== exp_def(k, 0)) begin
          errors++; bad_b = 1;
          $display("FAIL restart_b k=%0d actual=%h expected=%h", k, act_b, exp_def(k, 0));
        end
      end
      if (!bad_c) begin
        checks++;
        if (act_c !== exp_c(k)) begin
          errors++; bad_c = 1;
          $display("FAIL restart_c k=%0d actual=%h expected=%h", k, act_c, exp_c(k));
        end
      end
      if (hsync_a === 1'b0 && first_low_a < 0) first_low_a = k;
    end
    checks++;
    if (first_low_a != 659) begin
      errors++; $display("FAIL restart_hsync_first_low actual=%0d expected=659", first_low_a);
    end
  endtask

  initial begin
    clk     = 1'b0;
    reset_n = 1'b0;
    enable  = 1'b1;
    checks  = 0;
    errors  = 0;
    test_reset();
    $display("test_reset done: %0d checks, %0d errors", checks, errors);
    test_timing();
    $display("test_timing done: %0d checks, %0d errors", checks, errors);
    test_enable();
    $display("test_enable done: %0d checks, %0d errors", checks, errors);
    test_reset_midframe();
    $display("test_reset_midframe done: %0d checks, %0d errors", checks, errors);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
